// File: rtl/sdio_crc_lanes.sv
// Multi-lane serial CRC engine for SDIO: per-lane accumulate, then MSB-first shift-out.
// Define SDIO_CRC_CHECK_EN to add the receive-side CRC check (crc_chk/crc_err/crc_chk_vld).
module sdio_crc_lanes #(
  parameter int               LANES = 4,
  parameter int               CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY  = 16'h1021
) (
  input  logic                   sd_clk,
  input  logic                   rstn,
  input  logic                   sd_rst,
  input  logic                   crc_rst,
  input  logic                   crc_din_en,
  input  logic [LANES-1:0]       crc_din,
  input  logic                   crc_out_start,
`ifdef SDIO_CRC_CHECK_EN
  input  logic                   crc_chk,
  output logic [LANES-1:0]       crc_err,
  output logic                   crc_chk_vld,
`endif
  output logic [LANES*CRC_W-1:0] crc,
  output logic [LANES-1:0]       crc_dout,
  output logic                   crc_dout_vld,
  output logic                   crc_out_done,
  output logic                   busy
);

  // state | meaning
  // IDLE  | accumulate serial data; accept shift-out start (or check)
  // SHIFT | present CRC MSB-first on all lanes, one bit per cycle

  localparam int CNT_W = $clog2(CRC_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CRC_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state, state_nxt;
  logic [LANES*CRC_W-1:0]   crc_q, crc_nxt;
  logic [CNT_W-1:0]         cnt_q, cnt_nxt;
  logic [LANES-1:0]         dout_q, dout_nxt;
  logic                     vld_q, vld_nxt;
  logic                     done_q, done_nxt;
  logic [LANES-1:0]         shf_dout;
  logic [LANES*CRC_W-1:0]   shf_crc;
  logic [LANES*CRC_W-1:0]   upd_crc;
`ifdef SDIO_CRC_CHECK_EN
  logic [LANES-1:0]         err_q, err_nxt;
  logic                     chk_vld_q, chk_vld_nxt;
`endif

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] cur,
                                                input logic din);
    logic fb;
    fb = cur[CRC_W-1] ^ din;
    return {cur[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // Per-lane views shared by the start edge and the SHIFT cycles.
  always_comb begin
    shf_dout = '0;
    shf_crc  = '0;
    upd_crc  = '0;
    for (int l = 0; l < LANES; l++) begin
      shf_dout[l]                = crc_q[l*CRC_W + CRC_W - 1];
      shf_crc[l*CRC_W +: CRC_W]  = {crc_q[l*CRC_W +: CRC_W-1], 1'b0};
      upd_crc[l*CRC_W +: CRC_W]  = crc_step(crc_q[l*CRC_W +: CRC_W], crc_din[l]);
    end
  end

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc_q;
    cnt_nxt   = cnt_q;
    dout_nxt  = '0;
    vld_nxt   = 1'b0;
    done_nxt  = 1'b0;
`ifdef SDIO_CRC_CHECK_EN
    err_nxt     = err_q;
    chk_vld_nxt = 1'b0;
`endif
    if (sd_rst || crc_rst) begin
      state_nxt = IDLE;
      crc_nxt   = '0;
      cnt_nxt   = '0;
`ifdef SDIO_CRC_CHECK_EN
      err_nxt   = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef SDIO_CRC_CHECK_EN
          if (crc_chk) begin
            for (int l = 0; l < LANES; l++)
              err_nxt[l] = |crc_q[l*CRC_W +: CRC_W];
            chk_vld_nxt = 1'b1;
            crc_nxt     = '0;
          end else
`endif
          if (crc_out_start) begin
            // First bit is registered on the start edge so vld rises the next cycle.
            state_nxt = SHIFT;
            cnt_nxt   = CNT_LOAD;
            vld_nxt   = 1'b1;
            dout_nxt  = shf_dout;
            crc_nxt   = shf_crc;
          end else if (crc_din_en) begin
            crc_nxt = upd_crc;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            state_nxt = IDLE;
          end else begin
            vld_nxt  = 1'b1;
            dout_nxt = shf_dout;
            crc_nxt  = shf_crc;
            cnt_nxt  = cnt_q - 1'b1;
            done_nxt = (cnt_q == CNT_W'(1));
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      crc_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef SDIO_CRC_CHECK_EN
      err_q     <= '0;
      chk_vld_q <= 1'b0;
`endif
    end else begin
      crc_q  <= crc_nxt;
      cnt_q  <= cnt_nxt;
      dout_q <= dout_nxt;
      vld_q  <= vld_nxt;
      done_q <= done_nxt;
`ifdef SDIO_CRC_CHECK_EN
      err_q     <= err_nxt;
      chk_vld_q <= chk_vld_nxt;
`endif
    end
  end

  assign crc          = crc_q;
  assign crc_dout     = dout_q;
  assign crc_dout_vld = vld_q;
  assign crc_out_done = done_q;
  assign busy         = (state == SHIFT);
`ifdef SDIO_CRC_CHECK_EN
  assign crc_err      = err_q;
  assign crc_chk_vld  = chk_vld_q;
`endif

endmodule

// File: tb/tb_sdio_crc_lanes.sv
// Bench for sdio_crc_lanes: a CRC7 CMD instance and a 4-lane CRC16 DAT instance.
// Reference CRCs come from polynomial long division of the augmented message.
module tb_sdio_crc_lanes;

  logic sd_clk = 1'b0;
  logic rstn   = 1'b0;
  always #5 sd_clk = ~sd_clk;

  logic        a_sd_rst, a_crc_rst, a_din_en, a_start;
  logic [0:0]  a_din, a_dout;
  logic [6:0]  a_crc;
  logic        a_vld, a_done, a_busy;
  logic        b_sd_rst, b_crc_rst, b_din_en, b_start;
  logic [3:0]  b_din, b_dout;
  logic [63:0] b_crc;
  logic        b_vld, b_done, b_busy;
`ifdef SDIO_CRC_CHECK_EN
  logic        a_chk, a_chk_vld, b_chk, b_chk_vld;
  logic [0:0]  a_err;
  logic [3:0]  b_err;
`endif

  sdio_crc_lanes #(.LANES(1), .CRC_W(7), .POLY(7'h09)) u_a (
    .sd_clk(sd_clk), .rstn(rstn), .sd_rst(a_sd_rst), .crc_rst(a_crc_rst),
    .crc_din_en(a_din_en), .crc_din(a_din), .crc_out_start(a_start),
`ifdef SDIO_CRC_CHECK_EN
    .crc_chk(a_chk), .crc_err(a_err), .crc_chk_vld(a_chk_vld),
`endif
    .crc(a_crc), .crc_dout(a_dout), .crc_dout_vld(a_vld),
    .crc_out_done(a_done), .busy(a_busy));

  sdio_crc_lanes #(.LANES(4), .CRC_W(16), .POLY(16'h1021)) u_b (
    .sd_clk(sd_clk), .rstn(rstn), .sd_rst(b_sd_rst), .crc_rst(b_crc_rst),
    .crc_din_en(b_din_en), .crc_din(b_din), .crc_out_start(b_start),
`ifdef SDIO_CRC_CHECK_EN
    .crc_chk(b_chk), .crc_err(b_err), .crc_chk_vld(b_chk_vld),
`endif
    .crc(b_crc), .crc_dout(b_dout), .crc_dout_vld(b_vld),
    .crc_out_done(b_done), .busy(b_busy));

  typedef bit bq_t[$];
  typedef struct packed {
    logic [39:0] msg;
    logic [6:0]  exp;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  bq_t         qa;
  logic [3:0]  qb[$];
  vec_t        vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of M(x)*x^w divided by x^w + poly, MSB of remainder first.
  function automatic logic [31:0] ref_crc(input bq_t msg, input int w, input logic [31:0] poly);
    bq_t d;
    logic [31:0] r;
    r = '0;
    d = msg;
    for (int j = 0; j < w; j++) d.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (d[i])
        for (int j = 1; j <= w; j++) d[i+j] = d[i+j] ^ poly[w-j];
    for (int k = 0; k < w; k++) r[w-1-k] = d[msg.size()+k];
    return r;
  endfunction

  function automatic bq_t lane_q(input int l);
    bq_t q;
    foreach (qb[i]) q.push_back(qb[i][l]);
    return q;
  endfunction

  function automatic logic [63:0] b_model();
    logic [63:0] e;
    logic [31:0] r;
    e = '0;
    for (int l = 0; l < 4; l++) begin
      r = ref_crc(lane_q(l), 16, 32'h1021);
      e[l*16 +: 16] = r[15:0];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic a_bit(input logic v);
    a_din_en = 1'b1; a_din = v; tick(); a_din_en = 1'b0; qa.push_back(v);
  endtask

  task automatic a_byte(input logic [7:0] by);
    for (int i = 7; i >= 0; i--) a_bit(by[i]);
  endtask

  task automatic a_clear();
    a_crc_rst = 1'b1; tick(); a_crc_rst = 1'b0; qa.delete();
  endtask

  task automatic b_bits(input logic [3:0] v);
    b_din_en = 1'b1; b_din = v; tick(); b_din_en = 1'b0; qb.push_back(v);
  endtask

  task automatic b_clear();
    b_crc_rst = 1'b1; tick(); b_crc_rst = 1'b0; qb.delete();
  endtask

  // noise=1 also drives din_en at the start edge and holds start/din_en through SHIFT.
  task automatic a_shift(input logic [6:0] e, input logic noise, input string tag);
    a_start = 1'b1;
    if (noise) begin a_din_en = 1'b1; a_din = 1'b1; end
    tick();
    if (!noise) a_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("%s vld%0d", tag, k), a_vld, 1'b1);
      chk($sformatf("%s dout%0d", tag, k), a_dout, e[6-k]);
      chk($sformatf("%s done%0d", tag, k), a_done, k == 6);
      chk($sformatf("%s busy%0d", tag, k), a_busy, 1'b1);
      tick();
    end
    a_start = 1'b0; a_din_en = 1'b0;
    chk({tag, " vld_end"}, a_vld, 1'b0);
    chk({tag, " done_end"}, a_done, 1'b0);
    chk({tag, " busy_end"}, a_busy, 1'b0);
    chk({tag, " crc_end"}, a_crc, 7'h00);
    qa.delete();
  endtask

  task automatic b_shift(input logic [63:0] e, input string tag);
    logic [3:0] ed;
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 4; l++) ed[l] = e[l*16 + 15 - k];
      chk($sformatf("%s vld%0d", tag, k), b_vld, 1'b1);
      chk($sformatf("%s dout%0d", tag, k), b_dout, ed);
      chk($sformatf("%s done%0d", tag, k), b_done, k == 15);
      tick();
    end
    chk({tag, " vld_end"}, b_vld, 1'b0);
    chk({tag, " busy_end"}, b_busy, 1'b0);
    chk({tag, " crc_end"}, b_crc, 64'h0);
    qb.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [63:0] e;
    logic [3:0]  v, mask;
    logic        seen;
    int          n, pos;

    a_sd_rst = 0; a_crc_rst = 0; a_din_en = 0; a_din = '0; a_start = 0;
    b_sd_rst = 0; b_crc_rst = 0; b_din_en = 0; b_din = '0; b_start = 0;
`ifdef SDIO_CRC_CHECK_EN
    a_chk = 0; b_chk = 0;
`endif
    vecs[0] = '{msg: 40'h40_0000_0000, exp: 7'h4A};
    vecs[1] = '{msg: 40'h48_0000_01AA, exp: 7'h43};
    vecs[2] = '{msg: 40'h77_0000_0000, exp: 7'h32};
    vecs[3] = '{msg: 40'h69_4000_0000, exp: 7'h3B};

    repeat (3) tick();
    chk("rst a_crc", a_crc, 7'h0);
    chk("rst a_dout", a_dout, 1'b0);
    chk("rst a_vld", a_vld, 1'b0);
    chk("rst a_done", a_done, 1'b0);
    chk("rst a_busy", a_busy, 1'b0);
    chk("rst b_crc", b_crc, 64'h0);
    chk("rst b_vld", b_vld, 1'b0);
    chk("rst b_busy", b_busy, 1'b0);
`ifdef SDIO_CRC_CHECK_EN
    chk("rst a_err", a_err, 1'b0);
    chk("rst a_chk_vld", a_chk_vld, 1'b0);
`endif
    rstn = 1'b1;
    tick();

    // Known SDIO command frames on the CRC7 instance.
    for (int i = 0; i < 4; i++) begin
      a_clear();
      for (int bi = 39; bi >= 0; bi--) a_bit(vecs[i].msg[bi]);
      chk($sformatf("vec%0d crc", i), a_crc, vecs[i].exp);
      chk($sformatf("vec%0d model", i), a_crc, ref_crc(qa, 7, 32'h09));
    end

    a_clear();
    for (int bi = 39; bi >= 0; bi--) a_bit(vecs[1].msg[bi]);
    a_shift(7'h43, 1'b0, "cmd8_shift");

    // Start + din_en together, then start/din_en held during SHIFT: all ignored.
    a_clear();
    for (int bi = 39; bi >= 0; bi--) a_bit(vecs[0].msg[bi]);
    a_shift(7'h4A, 1'b1, "prio_shift");

    // sd_rst mid-SHIFT.
    a_clear();
    for (int bi = 39; bi >= 0; bi--) a_bit(vecs[0].msg[bi]);
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (2) tick();
    chk("sdrst pre vld", a_vld, 1'b1);
    a_sd_rst = 1'b1; tick(); a_sd_rst = 1'b0;
    chk("sdrst crc", a_crc, 7'h0);
    chk("sdrst dout", a_dout, 1'b0);
    chk("sdrst vld", a_vld, 1'b0);
    chk("sdrst done", a_done, 1'b0);
    chk("sdrst busy", a_busy, 1'b0);
    qa.delete();

    // 4096 ones on lane 0, zeros elsewhere.
    b_clear();
    for (int i = 0; i < 4096; i++) begin
      b_bits(4'b0001);
      if (i == 1023) begin
        chk("lanes1024 model", b_crc, b_model());
        chk("lanes1024 upper", b_crc[63:16], 48'h0);
      end
    end
    chk("ff512 crc", b_crc, 64'h7FA1);
    chk("ff512 model", b_crc, b_model());
    b_shift(64'h7FA1, "ff512_shift");

    // crc_rst on the 5th shift cycle.
    b_clear();
    for (int i = 0; i < 20; i++) b_bits(4'($urandom));
    chk("abort pre model", b_crc, b_model());
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("abort cyc5 vld", b_vld, 1'b1);
    b_crc_rst = 1'b1; tick(); b_crc_rst = 1'b0;
    chk("abort vld", b_vld, 1'b0);
    chk("abort done", b_done, 1'b0);
    chk("abort busy", b_busy, 1'b0);
    chk("abort crc", b_crc, 64'h0);
    seen = 1'b0;
    repeat (20) begin tick(); seen = seen | b_done | b_vld; end
    chk("abort no late done", seen, 1'b0);
    qb.delete();

    // Randomized frames with idle gaps.
    for (int it = 0; it < 24; it++) begin
      b_clear();
      n = $urandom_range(1, 80);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          b_din = 4'($urandom); tick();
        end
        b_bits(4'($urandom));
      end
      e = b_model();
      chk($sformatf("rnd_b%0d crc", it), b_crc, e);
      if (it % 3 == 0) b_shift(e, $sformatf("rnd_b%0d_shift", it));
    end
    for (int it = 0; it < 16; it++) begin
      a_clear();
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          a_din = 1'($urandom); tick();
        end
        a_bit(1'($urandom));
      end
      r = ref_crc(qa, 7, 32'h09);
      chk($sformatf("rnd_a%0d crc", it), a_crc, r);
      if (it % 4 == 0) a_shift(r[6:0], 1'b0, $sformatf("rnd_a%0d_shift", it));
    end

`ifdef SDIO_CRC_CHECK_EN
    // Good CMD0 frame with its CRC7 appended.
    a_clear();
    for (int bi = 39; bi >= 0; bi--) a_bit(vecs[0].msg[bi]);
    r = 32'h4A;
    for (int k = 6; k >= 0; k--) a_bit(r[k]);
    a_chk = 1'b1; tick(); a_chk = 1'b0;
    chk("chk good vld", a_chk_vld, 1'b1);
    chk("chk good err", a_err, 1'b0);
    tick();
    chk("chk good vld pulse", a_chk_vld, 1'b0);

    // One flipped CRC bit.
    a_clear();
    for (int bi = 39; bi >= 0; bi--) a_bit(vecs[0].msg[bi]);
    r = 32'h4B;
    for (int k = 6; k >= 0; k--) a_bit(r[k]);
    a_chk = 1'b1; tick(); a_chk = 1'b0;
    chk("chk bad vld", a_chk_vld, 1'b1);
    chk("chk bad err", a_err, 1'b1);
    chk("chk bad crc cleared", a_crc, 7'h0);
    qa.delete();
    for (int i = 0; i < 5; i++) a_bit(1'b1);
    chk("chk err hold", a_err, 1'b1);
    chk("chk vld low", a_chk_vld, 1'b0);

    // Check and start together: check wins; error clears on the good frame.
    a_clear();
    chk("crc_rst clears err", a_err, 1'b0);
    a_clear();
    for (int bi = 39; bi >= 0; bi--) a_bit(vecs[0].msg[bi]);
    a_bit(1'b0);
    a_chk = 1'b1; tick(); a_chk = 1'b0;
    chk("err set again", a_err, 1'b1);
    a_clear();
    for (int bi = 39; bi >= 0; bi--) a_bit(vecs[0].msg[bi]);
    r = 32'h4A;
    for (int k = 6; k >= 0; k--) a_bit(r[k]);
    a_chk = 1'b1; a_start = 1'b1; tick(); a_chk = 1'b0; a_start = 1'b0;
    chk("chk+start chk_vld", a_chk_vld, 1'b1);
    chk("chk+start dout_vld", a_vld, 1'b0);
    chk("chk+start busy", a_busy, 1'b0);
    chk("chk+start err", a_err, 1'b0);
    qa.delete();

    // Random 4-lane frames with a random set of corrupted lanes.
    for (int it = 0; it < 8; it++) begin
      b_clear();
      n = $urandom_range(8, 64);
      for (int i = 0; i < n; i++) b_bits(4'($urandom));
      e = b_model();
      mask = 4'($urandom);
      pos = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) begin
        for (int l = 0; l < 4; l++) v[l] = e[l*16 + 15 - k] ^ (mask[l] && (k == pos));
        b_bits(v);
      end
      b_chk = 1'b1; tick(); b_chk = 1'b0;
      chk($sformatf("chk_b%0d vld", it), b_chk_vld, 1'b1);
      chk($sformatf("chk_b%0d err", it), b_err, mask);
      chk($sformatf("chk_b%0d crc", it), b_crc, 64'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdio_crc_lanes.md
Name: sdio_crc_lanes

Overview:
- Parametrised multi-lane serial CRC engine for SDIO.
- One instance per bus direction. Covers CRC7 on the CMD line (LANES=1, CRC_W=7, POLY=7'h09) and CRC16 on DAT[3:0] (LANES=4, CRC_W=16, POLY=16'h1021).
- Accumulates CRC per lane from serial data, then shifts the CRC out MSB-first in lockstep on all lanes for transmit.
- Optionally checks received CRC for the receive path.

Parameters:
- LANES, 4, number of independent serial lanes (1..8).
- CRC_W, 16, CRC register width in bits (3..32).
- POLY, 16'h1021, generator polynomial without the x^CRC_W term, CRC_W bits wide.

Ports:
- sd_clk  input  1  bus-domain clock; all state changes on rising edge.
- rstn  input  1  asynchronous active-low reset.
- sd_rst  input  1  synchronous soft reset; same effect as rstn.
- crc_rst  input  1  synchronous clear of all lane CRCs; FSM returns to IDLE.
- crc_din_en  input  1  data bit valid on all lanes this cycle.
- crc_din  input  LANES  serial data bit per lane.
- crc_out_start  input  1  begin shifting the CRC out.
- crc  output  LANES*CRC_W  current CRC per lane; lane l occupies bits [l*CRC_W +: CRC_W].
- crc_dout  output  LANES  serial CRC bit per lane during shift-out.
- crc_dout_vld  output  1  high while crc_dout carries a CRC bit.
- crc_out_done  output  1  one-cycle pulse on the last shift-out bit.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (rstn low, or sd_rst high at the clock edge) sets:
  - crc = 0
  - crc_dout = 0
  - crc_dout_vld = 0
  - crc_out_done = 0
  - busy = 0
  - FSM = IDLE
  - bit counter = 0
- Per-lane update when crc_din_en=1 in IDLE:
  - fb = crc_l[CRC_W-1] ^ crc_din[l]
  - crc_l_next = {crc_l[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
  - One bit per lane per cycle; no latency beyond the register. crc reflects the bit on the next cycle.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on crc_out_start=1. Counter loads CRC_W-1.
  - SHIFT, each cycle:
    - crc_dout[l] = crc_l[CRC_W-1] (registered outputs, valid the cycle after start).
    - crc_l shifts left with zero fill.
    - crc_dout_vld=1, busy=1.
    - Counter decrements.
  - SHIFT -> IDLE when the counter is 0 and that bit has been presented. crc_out_done=1 aligns with the final crc_dout_vld cycle.
  - Net effect: exactly CRC_W vld cycles; crc is all zero afterwards.
- Priority per edge: sd_rst > crc_rst > crc_out_start > crc_din_en.
- crc_din_en in SHIFT: ignored; crc is not updated.
- crc_out_start in SHIFT: ignored; no restart.
- crc_out_start and crc_din_en in the same IDLE cycle: start wins; the data bit is dropped.
- crc_rst mid-SHIFT:
  - Aborts immediately.
  - crc_dout_vld drops next cycle; no crc_out_done pulse.
  - crc = 0.
- Counter width is $clog2(CRC_W). Wrap is impossible because the counter loads only from IDLE.
- Lanes are fully independent; no cross-lane terms.

Optional Feature:
- Macro: SDIO_CRC_CHECK_EN.
- When defined, adds:
  - input crc_chk (1)
  - output crc_err (LANES)
  - output crc_chk_vld (1)
- Receive usage: feed data bits and then the received CRC bits through crc_din/crc_din_en.
- crc_chk=1 in IDLE, one cycle later:
  - crc_err[l] = (crc_l != 0)
  - crc_chk_vld pulses one cycle
  - all lane CRCs clear
- crc_err holds until the next check, crc_rst, sd_rst or rstn.
- crc_chk in SHIFT is ignored.
- crc_chk has the same priority as crc_out_start. If both are asserted, check wins and start is ignored.
- Without the macro, these ports and their logic are absent.

Test Plan:
- CRC7, LANES=1, POLY=7'h09: feed CMD0 bits 40 00 00 00 00 MSB-first (40 enables) -> crc=7'h4A.
- CRC7, LANES=1: feed CMD8 48 00 00 01 AA -> crc=7'h43. Then pulse crc_out_start -> exactly 7 vld cycles with dout 1,0,0,0,0,1,1, done on the 7th, crc=0 after.
- CRC16, LANES=1, POLY=16'h1021: 4096 bits of 1 (512 bytes 0xFF) -> crc=16'h7FA1. Shift-out gives 16 bits 0111111110100001.
- LANES=4: lane0 all ones, lanes1..3 all zeros, 1024 bits each -> lane0 and lanes1..3 hold independent results; lanes1..3 crc=0.
  - crc_rst asserted on shift cycle 5 -> vld low next cycle, no done pulse, crc=0.
- Priority: crc_out_start and crc_din_en together in IDLE -> data bit dropped, CRC unchanged before shift.
  - sd_rst mid-SHIFT -> all outputs at reset values next cycle.
- SDIO_CRC_CHECK_EN: feed CMD0 40 00 00 00 00 plus 7 bits 1001010, then crc_chk -> crc_err=0, crc_chk_vld one cycle.
  - Repeat with one flipped CRC bit -> crc_err=1, held until the next check.
